instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter N, default 512, instruction memory depth in words.
REQ-002 Parameter DW, default 32, instruction word width.
REQ-003 Parameter STOP_OPC, default 32'd6, word served for PCs at or beyond the loaded length.
REQ-004 CLK  in  1  single clock; all logic rising-edge.
REQ-005 RSTN  in  1  synchronous, active-high reset (asserted = 1).
REQ-006 ld_valid  in  1  host program word valid.
REQ-007 ld_ready  out  1  loader accepts word this cycle.
REQ-008 ld_data  in  DW  program word.
REQ-009 ld_last  in  1  marks final word of program.
REQ-010 go  in  1  single-cycle pulse; start or restart execution.
REQ-011 PC_AXI  in  $clog2(N)  core fetch address.
REQ-012 INSTR_AXI  out  DW  instruction for PC_AXI.
REQ-013 START_SIGNAL  out  1  core run enable.
REQ-014 STOP_SIGNAL  in  1  core reports STOP executed.
REQ-015 prog_len  out  $clog2(N)+1  words held in the current program.
REQ-016 busy  out  1  high in LOAD or RUN.
REQ-017 done  out  1  high in DONE.
REQ-018 run_cycles  out  32  cycles spent in RUN by the last/current run.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, READY, RUN, DONE.
REQ-020 A word SHALL transfer on ld_valid && ld_ready; it is written at wr_ptr, and wr_ptr increments.
REQ-021 ld_ready SHALL be 1 in IDLE, LOAD, READY, DONE when wr_ptr < N, and 0 in RUN.
REQ-022 IDLE/READY/DONE + ld_valid -> LOAD; the word SHALL be written at address 0, prog_len cleared, and wr_ptr set to 1.
REQ-023 LOAD: transfer with ld_last, or transfer with wr_ptr == N-1, -> READY; prog_len = words written.
REQ-024 go SHALL be ignored in IDLE, LOAD, RUN; in READY or DONE, go -> RUN, run_cycles cleared to 0.
REQ-025 go and ld_valid in the same READY/DONE cycle: load SHALL win; go dropped.
REQ-026 START_SIGNAL SHALL be 1 exactly while in RUN, asserted the cycle after go is accepted.
REQ-027 INSTR_AXI SHALL be registered: 1-cycle latency from PC_AXI, mem[PC_AXI] if PC_AXI < prog_len, else STOP_OPC.
REQ-028 A write and a read at the same address in the same cycle SHALL return old data (read-first).
REQ-029 RUN: run_cycles SHALL increment every cycle, saturating at 2^32-1.
REQ-030 RUN + STOP_SIGNAL -> DONE; run_cycles SHALL freeze, and STOP_SIGNAL outside RUN is ignored.
REQ-031 prog_len == 0 is unreachable from READY; go in IDLE stays ignored.
REQ-032 Memory contents SHALL persist across DONE -> RUN restarts.

Reset
REQ-033 On RSTN: state IDLE, wr_ptr 0, prog_len 0, INSTR_AXI STOP_OPC, START_SIGNAL 0, busy 0, done 0, run_cycles 0; memory contents are not cleared.
REQ-034 Reset mid-LOAD or mid-RUN SHALL abort immediately; START_SIGNAL is 0 the cycle after the reset edge.

Structure
REQ-035 The shared package SHALL hold the FSM state enum, N, DW, and the STOP_OPC constant shared with the core decoder.
REQ-036 Storage SHALL be one sub-module, instr_ram: 1 write port, 1 registered read port, N x DW, BRAM-inferable.

Verification
REQ-037 Load 3 words (0x2322, 0x0722, 0x6) with last on word 3 -> READY, prog_len = 3, ld_ready stays 1.
REQ-038 go, then PC_AXI = 0,1,2,3 -> INSTR_AXI = 0x2322, 0x0722, 0x6, 0x6, each one cycle later; START_SIGNAL 1.
REQ-039 STOP_SIGNAL pulse after 20 RUN cycles -> DONE, done = 1, START_SIGNAL 0, run_cycles = 20.
REQ-040 Stream 512 words with no last -> READY after word 512, prog_len = 512, ld_ready 0 afterwards.
REQ-041 go and ld_valid in the same DONE cycle -> LOAD, word at address 0, START_SIGNAL stays 0.
REQ-042 RSTN during RUN -> IDLE next cycle, START_SIGNAL 0, INSTR_AXI = 0x6, prog_len = 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared loader types and constants
// The core decoder uses the same STOP opcode value.
package instr_loader_pkg;

  localparam int          DEF_N         = 512;
  localparam int          DEF_DW        = 32;
  localparam logic [31:0] STOP_OPC_WORD = 32'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/instr_loader_ram.sv
// rtl/instr_loader_ram.sv - N x DW instruction store, one write port, one registered read port
// Read-first behaviour and no reset keep this mappable onto a block RAM.
module instr_ram #(
  parameter int N  = 512,
  parameter int DW = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - host program loader and run controller for the core
// Loads a program into instr_ram, then serves fetches while counting run cycles.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          N        = DEF_N,
  parameter int          DW       = DEF_DW,
  parameter logic [DW-1:0] STOP_OPC = STOP_OPC_WORD[DW-1:0]
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DW-1:0]        ld_data,
  input  logic                 ld_last,
  input  logic                 go,
  input  logic [$clog2(N)-1:0] PC_AXI,
  output logic [DW-1:0]        INSTR_AXI,
  output logic                 START_SIGNAL,
  input  logic                 STOP_SIGNAL,
  output logic [$clog2(N):0]   prog_len,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          run_cycles
);

  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] prog_len_q, prog_len_d;
  logic [31:0]   run_cycles_q, run_cycles_d;
  logic          sel_q;
  logic          xfer;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_rdata;

  assign ld_ready = (state_q != S_RUN) && (wr_ptr_q < PW'(N));
  assign xfer     = ld_valid && ld_ready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    run_cycles_d = run_cycles_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[AW-1:0];
    case (state_q)
      S_IDLE, S_READY, S_DONE: begin
        // A new word always restarts the program at address 0 and beats go.
        if (xfer) begin
          ram_we     = 1'b1;
          ram_waddr  = '0;
          wr_ptr_d   = PW'(1);
          prog_len_d = '0;
          if (ld_last) begin
            state_d    = S_READY;
            prog_len_d = PW'(1);
          end else begin
            state_d = S_LOAD;
          end
        end else if (go && state_q != S_IDLE) begin
          state_d      = S_RUN;
          run_cycles_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (ld_last || wr_ptr_q == PW'(N - 1)) begin
            state_d    = S_READY;
            prog_len_d = wr_ptr_q + PW'(1);
          end
        end
      end
      S_RUN: begin
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
        if (STOP_SIGNAL) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      run_cycles_q <= '0;
      sel_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      run_cycles_q <= run_cycles_d;
      sel_q        <= PW'(PC_AXI) < prog_len_q;
    end
  end

  instr_ram #(
    .N  (N),
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ld_data),
    .raddr_i (PC_AXI),
    .rdata_o (ram_rdata)
  );

  // Fetches past the program end see STOP so the core halts cleanly.
  assign INSTR_AXI    = sel_q ? ram_rdata : STOP_OPC;
  assign START_SIGNAL = (state_q == S_RUN);
  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign prog_len     = prog_len_q;
  assign run_cycles   = run_cycles_q;

endmodule
